tcam_cfg_sequencer: RTL

TCAM_CFG_SEQUENCER -- requirements
Module: tcam_cfg_sequencer

---
 rtl/tcam_cfg_sequencer.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/tcam_cfg_sequencer.sv
// Host-driven TCAM/action table update sequencer: drains in-flight lookups,
// then writes mask, value and action (or the default action) for one entry.
module tcam_cfg_sequencer #(
    parameter int unsigned ENTRIES   = 16,
    parameter int unsigned KEY_W     = 128,
    parameter int unsigned ACTION_W  = 64,
    parameter int unsigned DRAIN_CYC = 4,
    localparam int unsigned IDX_W    = (ENTRIES > 1) ? $clog2(ENTRIES) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_op,
    input  logic [IDX_W-1:0]    cmd_idx,
    input  logic [KEY_W-1:0]    cmd_value,
    input  logic [KEY_W-1:0]    cmd_mask,
    input  logic [ACTION_W-1:0] cmd_action,
    input  logic                key_valid_in,
    output logic                key_ready_out,
    output logic                key_valid_out,
    output logic                tcam_wr_en,
    output logic                tcam_wr_is_mask,
    output logic [IDX_W-1:0]    tcam_wr_addr,
    output logic [KEY_W-1:0]    tcam_wr_data,
    output logic                action_wr_en,
    output logic [IDX_W-1:0]    action_wr_addr,
    output logic [ACTION_W-1:0] action_wr_data,
    output logic                action_wr_default,
    output logic [ACTION_W-1:0] action_default_data,
    output logic                cmd_done,
    output logic                cmd_err,
    output logic [15:0]         upd_count
);

    localparam int unsigned CNT_W = 8;
    localparam logic [1:0] OP_INSTALL = 2'b00;
    localparam logic [1:0] OP_DELETE  = 2'b01;
    localparam logic [1:0] OP_DEFAULT = 2'b10;
    localparam logic [1:0] OP_ILLEGAL = 2'b11;

    typedef enum logic [2:0] {
        IDLE, DRAIN, WR_MASK, WR_VAL, WR_ACT, WR_DEF, DONE, ERR
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [1:0]          op_q;
    logic [IDX_W-1:0]    idx_q;
    logic [KEY_W-1:0]    value_q;
    logic [KEY_W-1:0]    mask_q;
    logic [ACTION_W-1:0] action_q;
    logic [CNT_W-1:0]    drain_cnt;
    logic                accept;
    logic                cmd_illegal;
    logic                is_delete;

    assign accept      = cmd_valid && (state == IDLE);
    assign cmd_illegal = (cmd_op == OP_ILLEGAL) ||
                         ((cmd_op != OP_DEFAULT) && (32'(cmd_idx) >= ENTRIES));
    assign is_delete   = (op_q == OP_DELETE);

    // Lookups pass only while no table update is in progress.
    assign key_valid_out = key_valid_in && key_ready_out;

    // Next-state logic.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (accept) state_next = cmd_illegal ? ERR : DRAIN;
            DRAIN:   if (drain_cnt == '0)
                         state_next = (op_q == OP_DEFAULT) ? WR_DEF : WR_MASK;
            WR_MASK: state_next = WR_VAL;
            WR_VAL:  state_next = WR_ACT;
            WR_ACT:  state_next = DONE;
            WR_DEF:  state_next = DONE;
            DONE:    state_next = IDLE;
            ERR:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State, captured command fields and registered outputs (decoded from next state).
    always_ff @(posedge clk) begin
        if (rst) begin
            state               <= IDLE;
            op_q                <= OP_INSTALL;
            idx_q               <= '0;
            value_q             <= '0;
            mask_q              <= '0;
            action_q            <= '0;
            drain_cnt           <= '0;
            cmd_ready           <= 1'b1;
            key_ready_out       <= 1'b1;
            tcam_wr_en          <= 1'b0;
            tcam_wr_is_mask     <= 1'b0;
            tcam_wr_addr        <= '0;
            tcam_wr_data        <= '0;
            action_wr_en        <= 1'b0;
            action_wr_addr      <= '0;
            action_wr_data      <= '0;
            action_wr_default   <= 1'b0;
            action_default_data <= '0;
            cmd_done            <= 1'b0;
            cmd_err             <= 1'b0;
            upd_count           <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                op_q      <= cmd_op;
                idx_q     <= cmd_idx;
                value_q   <= cmd_value;
                mask_q    <= cmd_mask;
                action_q  <= cmd_action;
                drain_cnt <= CNT_W'(DRAIN_CYC - 1);
            end else if ((state == DRAIN) && (drain_cnt != '0)) begin
                drain_cnt <= drain_cnt - CNT_W'(1);
            end

            cmd_ready           <= (state_next == IDLE);
            key_ready_out       <= (state_next == IDLE) || (state_next == ERR);
            tcam_wr_en          <= (state_next == WR_MASK) || (state_next == WR_VAL);
            tcam_wr_is_mask     <= (state_next == WR_MASK);
            tcam_wr_addr        <= idx_q;
            // Delete parks the entry on an all-ones key with all bits cared.
            tcam_wr_data        <= is_delete ? '1 :
                                   ((state_next == WR_MASK) ? mask_q : value_q);
            action_wr_en        <= (state_next == WR_ACT);
            action_wr_addr      <= idx_q;
            action_wr_data      <= is_delete ? '0 : action_q;
            action_wr_default   <= (state_next == WR_DEF);
            action_default_data <= action_q;
            cmd_done            <= (state_next == DONE) || (state_next == ERR);
            cmd_err             <= (state_next == ERR);
            if ((state_next == DONE) && (upd_count != 16'hFFFF))
                upd_count <= upd_count + 16'd1;
        end
    end

endmodule
